// File: rtl/onchip_mem_arbiter_if.sv
// Bus bundle for onchip_mem_arbiter: two Avalon-style request ports, the
// memory-side s1 signals and the sticky out-of-range flag.
interface onchip_mem_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] s0_address,  s1_address;
    logic              s0_read,     s1_read;
    logic              s0_write,    s1_write;
    logic [3:0]        s0_byteenable, s1_byteenable;
    logic [31:0]       s0_writedata,  s1_writedata;
    logic              s0_waitrequest, s1_waitrequest;
    logic [31:0]       s0_readdata,    s1_readdata;
    logic              s0_readdatavalid, s1_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_debugaccess;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              oor_err;

    // Requesting side (masters plus the memory model that returns readdata).
    modport master (
        output s0_address, s0_read, s0_write, s0_byteenable, s0_writedata,
        output s1_address, s1_read, s1_write, s1_byteenable, s1_writedata,
        input  s0_waitrequest, s0_readdata, s0_readdatavalid,
        input  s1_waitrequest, s1_readdata, s1_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write,
        input  mem_debugaccess, mem_writedata, oor_err,
        output mem_readdata
    );

    // Arbiter side.
    modport slave (
        input  s0_address, s0_read, s0_write, s0_byteenable, s0_writedata,
        input  s1_address, s1_read, s1_write, s1_byteenable, s1_writedata,
        output s0_waitrequest, s0_readdata, s0_readdatavalid,
        output s1_waitrequest, s1_readdata, s1_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write,
        output mem_debugaccess, mem_writedata, oor_err,
        input  mem_readdata
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-port arbiter for the single-port program memory (port 0 = Nios, port 1 = debug).
// Define ONCHIP_ARB_ROUND_ROBIN_EN for round-robin; otherwise port 0 has fixed priority.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 2560
) (
    input  logic               clk,
    input  logic               reset_n,
    onchip_mem_arbiter_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][3:0]        be;
    logic [1:0][31:0]       wdata;
    logic [1:0]             rd, wr, req;

    assign addr  = {bus.s1_address,    bus.s0_address};
    assign be    = {bus.s1_byteenable, bus.s0_byteenable};
    assign wdata = {bus.s1_writedata,  bus.s0_writedata};
    assign rd    = {bus.s1_read,  bus.s0_read};
    assign wr    = {bus.s1_write, bus.s0_write};
    assign req   = rd | wr;

    logic pend_valid_q, pend_valid_d;
    logic pend_port_q,  pend_port_d;
    logic pend_oor_q,   pend_oor_d;
    logic oor_err_q,    oor_err_d;

    logic              gnt_any, gnt_port;
    logic [ADDR_W-1:0] sel_addr;
    logic              in_range, g_rd, g_wr;

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    always_ff @(posedge clk) begin
        if (!reset_n)     last_grant_q <= 1'b1;
        else if (gnt_any) last_grant_q <= gnt_port;
    end

    assign gnt_port = (&req) ? ~last_grant_q : req[1];
`else
    assign gnt_port = ~req[0] & req[1];
`endif

    // Nothing is granted while in reset, so both waitrequests read high.
    assign gnt_any  = reset_n & (|req);
    assign sel_addr = addr[gnt_port];
    assign in_range = {1'b0, sel_addr} < DEPTH_L;
    assign g_rd     = gnt_any & rd[gnt_port];
    assign g_wr     = gnt_any & wr[gnt_port];

    always_comb begin
        pend_valid_d = g_rd;
        pend_port_d  = gnt_port;
        pend_oor_d   = ~in_range;
        // Port-0 writes are silently dropped and never raise the flag.
        oor_err_d    = oor_err_q | (gnt_any & ~in_range & ~(g_wr & ~gnt_port));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_valid_q <= 1'b0;
            pend_port_q  <= 1'b0;
            pend_oor_q   <= 1'b0;
            oor_err_q    <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_port_q  <= pend_port_d;
            pend_oor_q   <= pend_oor_d;
            oor_err_q    <= oor_err_d;
        end
    end

    assign bus.s0_waitrequest  = ~(gnt_any & ~gnt_port);
    assign bus.s1_waitrequest  = ~(gnt_any &  gnt_port);

    assign bus.mem_address     = sel_addr;
    assign bus.mem_byteenable  = be[gnt_port];
    assign bus.mem_writedata   = wdata[gnt_port];
    assign bus.mem_write       = g_wr & gnt_port & in_range;
    assign bus.mem_debugaccess = g_wr & gnt_port & in_range;
    assign bus.mem_chipselect  = (g_rd & in_range) | (g_wr & gnt_port & in_range);
    assign bus.oor_err         = oor_err_q;

    logic cpl0, cpl1;
    assign cpl0 = pend_valid_q & ~pend_port_q;
    assign cpl1 = pend_valid_q &  pend_port_q;

    assign bus.s0_readdatavalid = cpl0;
    assign bus.s1_readdatavalid = cpl1;
    assign bus.s0_readdata      = (cpl0 & ~pend_oor_q) ? bus.mem_readdata : 32'h0;
    assign bus.s1_readdata      = (cpl1 & ~pend_oor_q) ? bus.mem_readdata : 32'h0;
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed + random bench for onchip_mem_arbiter against a transaction-level model
// (reference memory, preferred-port bit, one-entry expected completion).
module tb_onchip_mem_arbiter;
    localparam int DEPTH = 2560;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } req_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    onchip_mem_arbiter_if #(.ADDR_W(12)) bus();
    onchip_mem_arbiter #(.ADDR_W(12), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    // Physical memory behind the arbiter: one-cycle read latency, byte writes.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (bus.mem_chipselect) begin
            if (bus.mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_byteenable[b]) mem[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
            end else begin
                bus.mem_readdata <= mem[bus.mem_address];
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:4095];
    bit          m_pv, m_pp, m_oor, m_pref;
    logic [31:0] m_pd;

    int nchk = 0, npass = 0, nfail = 0;
    int obs_g;
    int cnt_rdv0, cnt_rdv1;
    int gseq [8];

    req_t idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input bit rd, input bit wr, input int addr, input logic [3:0] be, input logic [31:0] d);
        req_t q;
        q.rd = rd; q.wr = wr; q.addr = 12'(addr); q.be = be; q.data = d;
        return q;
    endfunction

    function automatic req_t rnd_req();
        req_t q;
        int k = $urandom_range(0, 3);
        int sel = $urandom_range(0, 9);
        q = '0;
        q.rd = (k == 1);
        q.wr = (k == 2);
        if (sel == 0)      q.addr = 12'($urandom_range(DEPTH, 4095));
        else if (sel == 1) q.addr = 12'($urandom_range(DEPTH - 8, DEPTH - 1));
        else               q.addr = 12'($urandom_range(0, 31));
        q.be   = 4'($urandom);
        q.data = $urandom;
        return q;
    endfunction

    // One bus cycle: drive, check outputs mid-cycle against the model, advance model.
    task automatic step(input req_t q0, input req_t q1, input bit rst_lo = 1'b0);
        bit r0, r1, gv, g, inr, exp_cs, exp_mw;
        req_t qg;
        @(negedge clk);
        reset_n = ~rst_lo;
        bus.s0_read = q0.rd; bus.s0_write = q0.wr; bus.s0_address = q0.addr;
        bus.s0_byteenable = q0.be; bus.s0_writedata = q0.data;
        bus.s1_read = q1.rd; bus.s1_write = q1.wr; bus.s1_address = q1.addr;
        bus.s1_byteenable = q1.be; bus.s1_writedata = q1.data;
        #1;
        chk("rdv0",  bus.s0_readdatavalid, m_pv && !m_pp);
        chk("rdv1",  bus.s1_readdatavalid, m_pv &&  m_pp);
        chk("rdata0", bus.s0_readdata, (m_pv && !m_pp) ? m_pd : 32'h0);
        chk("rdata1", bus.s1_readdata, (m_pv &&  m_pp) ? m_pd : 32'h0);
        chk("oor_err", bus.oor_err, m_oor);
        cnt_rdv0 += int'(bus.s0_readdatavalid);
        cnt_rdv1 += int'(bus.s1_readdatavalid);

        r0 = q0.rd | q0.wr;
        r1 = q1.rd | q1.wr;
        gv = !rst_lo && (r0 || r1);
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
        g  = (r0 && r1) ? m_pref : r1;
`else
        g  = !r0 && r1;
`endif
        chk("wait0", bus.s0_waitrequest, !(gv && !g));
        chk("wait1", bus.s1_waitrequest, !(gv &&  g));
        obs_g = !bus.s0_waitrequest ? 0 : (!bus.s1_waitrequest ? 1 : 2);

        qg     = g ? q1 : q0;
        inr    = qg.addr < DEPTH;
        exp_mw = gv && inr && qg.wr && g;
        exp_cs = gv && inr && (qg.rd || exp_mw);
        chk("chipsel", bus.mem_chipselect, exp_cs);
        chk("mem_wr",  bus.mem_write, exp_mw);
        chk("dbgacc",  bus.mem_debugaccess, exp_mw);
        if (exp_cs) chk("mem_addr", bus.mem_address, qg.addr);
        if (exp_mw) chk("mem_wdat", bus.mem_writedata, qg.data);

        if (rst_lo) begin
            m_pv = 0; m_oor = 0; m_pref = 0;
        end else begin
            m_pv = gv && qg.rd;
            m_pp = g;
            m_pd = inr ? ref_mem[qg.addr] : 32'h0;
            if (gv && !inr && !(qg.wr && !g)) m_oor = 1;
            if (gv) m_pref = !g;
            if (exp_mw)
                for (int b = 0; b < 4; b++)
                    if (qg.be[b]) ref_mem[qg.addr][8*b +: 8] = qg.data[8*b +: 8];
        end
    endtask

    initial begin
        idle = '0;
        for (int i = 0; i < 4096; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        bus.s0_read = 0; bus.s0_write = 0; bus.s0_address = '0; bus.s0_byteenable = '0; bus.s0_writedata = '0;
        bus.s1_read = 0; bus.s1_write = 0; bus.s1_address = '0; bus.s1_byteenable = '0; bus.s1_writedata = '0;
        bus.mem_readdata = 32'h0;
        m_pv = 0; m_pp = 0; m_pd = 0; m_oor = 0; m_pref = 0;
        repeat (2) @(posedge clk);

        // Reset: both waitrequests high even with both ports requesting.
        step(mk(1, 0, 1, 4'hF, 0), mk(1, 0, 2, 4'hF, 0), 1'b1);
        chk("rst_wait0", bus.s0_waitrequest, 1'b1);
        chk("rst_wait1", bus.s1_waitrequest, 1'b1);

        // Both ports read continuously for 8 cycles.
        cnt_rdv0 = 0; cnt_rdv1 = 0;
        for (int i = 0; i < 8; i++) begin
            step(mk(1, 0, i, 4'hF, 0), mk(1, 0, 16 + i, 4'hF, 0));
            gseq[i] = obs_g;
        end
        step(idle, idle);
        for (int i = 0; i < 8; i++) begin
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
            chk($sformatf("rr_gnt%0d", i), 32'(gseq[i]), 32'(i % 2));
`else
            chk($sformatf("fp_gnt%0d", i), 32'(gseq[i]), 32'h0);
`endif
        end
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
        chk("rr_cnt0", 32'(cnt_rdv0), 32'd4);
        chk("rr_cnt1", 32'(cnt_rdv1), 32'd4);
`else
        chk("fp_cnt0", 32'(cnt_rdv0), 32'd8);
        chk("fp_cnt1", 32'(cnt_rdv1), 32'd0);
`endif

        // Debug write then Nios read-back.
        step(idle, mk(0, 1, 5, 4'hF, 32'hCAFEF00D));
        step(mk(1, 0, 5, 4'hF, 0), idle);
        step(idle, idle);
        chk("rb_valid", bus.s0_readdatavalid, 1'b1);
        chk("rb_data",  bus.s0_readdata, 32'hCAFEF00D);

        // Nios write is accepted but dropped.
        step(mk(0, 1, 5, 4'hF, 32'h12345678), idle);
        chk("p0wr_wait", bus.s0_waitrequest, 1'b0);
        chk("p0wr_cs",   bus.mem_chipselect, 1'b0);
        step(mk(1, 0, 5, 4'hF, 0), idle);
        step(idle, idle);
        chk("p0wr_data", bus.s0_readdata, 32'hCAFEF00D);

        // Single-byte debug write.
        step(idle, mk(0, 1, 5, 4'b0010, 32'h0000AB00));
        step(idle, mk(1, 0, 5, 4'hF, 0));
        step(idle, idle);
        chk("be_valid", bus.s1_readdatavalid, 1'b1);
        chk("be_data",  bus.s1_readdata, 32'hCAFEAB0D);

        // First out-of-range address.
        step(mk(1, 0, DEPTH, 4'hF, 0), idle);
        chk("oor_cs", bus.mem_chipselect, 1'b0);
        step(idle, idle);
        chk("oor_valid", bus.s0_readdatavalid, 1'b1);
        chk("oor_data",  bus.s0_readdata, 32'h0);
        chk("oor_flag",  bus.oor_err, 1'b1);
        repeat (3) step(idle, mk(1, 0, 7, 4'hF, 0));
        chk("oor_sticky", bus.oor_err, 1'b1);

        // Read request presented during reset is never completed.
        step(mk(1, 0, 5, 4'hF, 0), idle, 1'b1);
        chk("mrst_wait0", bus.s0_waitrequest, 1'b1);
        chk("mrst_wait1", bus.s1_waitrequest, 1'b1);
        step(idle, idle);
        chk("mrst_rdv", bus.s0_readdatavalid, 1'b0);
        chk("mrst_oor", bus.oor_err, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) step(rnd_req(), rnd_req());
        step(idle, idle);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-port arbiter that shares the single-port on-chip program memory (4096-word address space, 2560 words populated, 32-bit, byte-enabled, one-cycle read latency) between the Nios II instruction/data master (port 0) and the debug/loader master (port 1). It grants at most one transfer per cycle and steers read data back to the issuing port. It filters writes so only the debug port can modify memory, and it flags out-of-range accesses. It sits between the Qsys interconnect masters and the memory's s1 slave.

## Interface
Parameters:
- ADDR_W, 12, word address width
- DEPTH, 2560, number of populated words; addresses >= DEPTH are out of range

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- s0_address / s1_address  in  ADDR_W  word address, port 0 / port 1
- s0_read, s0_write / s1_read, s1_write  in  1  transfer request; read and write never both high on one port
- s0_byteenable / s1_byteenable  in  4  byte lanes
- s0_writedata / s1_writedata  in  32  write data
- s0_waitrequest / s1_waitrequest  out  1  high = request not accepted this cycle
- s0_readdata / s1_readdata  out  32  read data
- s0_readdatavalid / s1_readdatavalid  out  1  read data valid
- mem_address  out  ADDR_W  memory address
- mem_byteenable  out  4  memory byte enables
- mem_chipselect  out  1  memory select
- mem_write  out  1  memory write
- mem_debugaccess  out  1  high only for port-1 writes
- mem_writedata  out  32  memory write data
- mem_readdata  in  32  memory read data, valid the cycle after the address is issued
- oor_err  out  1  sticky out-of-range flag

## Operation
- Request: sN_req = sN_read | sN_write.
- Grant selection is combinational each cycle:
  - One port requesting: that port is granted.
  - Both ports requesting: grant goes opposite last_grant (round-robin; see Configuration).
- last_grant updates only on a cycle with a grant.
- sN_waitrequest = ~(grant to N) while reset_n is high. Both are high while reset_n is low.
- Granted, in-range read: mem_chipselect=1, mem_write=0, granted port's address and byteenable driven to the memory.
- Granted, in-range write from port 1: mem_chipselect=1, mem_write=1, mem_debugaccess=1.
- Granted write from port 0: accepted (waitrequest low) but dropped. mem_chipselect=0, memory untouched, no error.
- Granted access with address >= DEPTH: accepted, not issued (mem_chipselect=0), oor_err set.
  - Out-of-range read completes with readdata = 32'h0.
- No grant: mem_chipselect=0, mem_write=0, mem_debugaccess=0. Address, byteenable and writedata outputs are don't-care.
- Read pending register captures {valid, port, oor} on every granted read. Back-to-back reads from either port are fully pipelined, one per cycle.
- Completion: sN_readdatavalid = pend_valid & (pend_port==N). sN_readdata = pend_oor ? 0 : mem_readdata (combinational pass-through). The readdata of the port not being completed is 0.
- oor_err clears only on reset.

## Timing
- Read latency: request granted in cycle N; readdatavalid high in cycle N+1 only.
- Writes complete in the grant cycle and produce no readdatavalid.
- Throughput: one transfer per cycle total.
  - Round-robin with both ports continuously requesting: grants alternate 0,1,0,1.
- Reset values (reset_n low at an edge):
  - last_grant=1, so port 0 wins the first conflict.
  - pend_valid=0, oor_err=0.
  - All readdatavalid outputs 0 in the following cycle.
- Reset mid-read: a read granted in the cycle reset is sampled is discarded; no readdatavalid is produced for it.
- A completion (readdatavalid) and a new grant to the same port in the same cycle are legal.

## Configuration
- ONCHIP_ARB_ROUND_ROBIN_EN:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority; port 0 always wins a conflict and last_grant is unused. Port 1 may starve under continuous port-0 traffic. All other behaviour is identical.

## Test plan
- Port 1 writes 32'hCAFEF00D to address 5 (byteenable 4'hF); port 0 then reads address 5 -> s0_readdatavalid high one cycle after grant, s0_readdata = 32'hCAFEF00D.
- Port 0 writes 32'h12345678 to address 5 -> s0_waitrequest low, mem_chipselect 0; a later read returns 32'hCAFEF00D.
- Both ports read continuously for 8 cycles with ONCHIP_ARB_ROUND_ROBIN_EN -> grants 0,1,0,1,0,1,0,1 with 4 readdatavalid each. Without the macro -> 8 port-0 grants, s1_waitrequest stays high.
- Port 0 reads address 2560 -> mem_chipselect 0, s0_readdata 0 with readdatavalid next cycle, oor_err 1 and held until reset.
- Port 0 read granted, then reset_n low for that edge -> no s0_readdatavalid, oor_err 0, both waitrequest high while reset_n low.
- Port 1 byteenable 4'b0010 write of 32'h0000AB00 to a word holding 32'hCAFEF00D -> a subsequent read returns 32'hCAFEAB0D.
